tetris_line_clear: RTL and testbench

- Post-placement stage between the Tetris game logic and vga_controller.
- Accepts a locked-down playfield snapshot and removes every completely filled row, collapsing the rows above it downward.
- Holds the resulting field as the registered 400-bit field bus consumed by vga_controller.
- Reports lines cleared per pass and keeps a running score.

---
 rtl/tetris_line_clear.sv | 129 ++++++++++++
 tb/tb_tetris_line_clear.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_line_clear.sv
// Line-clear pass between game logic and vga_controller: removes full rows, collapses the field, reports lines/score.
// Optional scoring is compiled only when LINE_CLEAR_SCORE_EN is defined; otherwise score is tied to 0.
module tetris_line_clear #(
  parameter int ROWS    = 20,
  parameter int COLS    = 20,
  parameter int SCORE_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   field_in,
  output logic [ROWS*COLS-1:0]   field_out,
  output logic                   busy,
  output logic                   done,
  output logic [4:0]             lines_last,
  output logic [SCORE_W-1:0]     score
);

  localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state, state_next;
  logic [R_W-1:0]         r;
  logic [4:0]             n;
  logic [COLS-1:0]        rows [ROWS];
  logic [ROWS*COLS-1:0]   shifted;
  logic                   row_full;

  always_comb begin
    for (int unsigned k = 0; k < ROWS; k++) begin
      rows[k] = field_out[k*COLS +: COLS];
    end
  end

  assign row_full = &rows[r];

  // Rows 1..r take the row above them; row 0 refills empty; rows below r stay put.
  always_comb begin
    shifted = field_out;
    for (int unsigned k = 0; k < ROWS; k++) begin
      if (k == 0) begin
        shifted[k*COLS +: COLS] = '0;
      end else if (k <= 32'(r)) begin
        shifted[k*COLS +: COLS] = rows[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (!row_full && (r == '0)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      field_out  <= '0;
      r          <= '0;
      n          <= '0;
      lines_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            field_out <= field_in;
            r         <= R_W'(ROWS - 1);
            n         <= '0;
          end
        end
        SCAN: begin
          if (row_full) begin
            field_out <= shifted;
            n         <= n + 5'd1;
          end else if (r != '0) begin
            r <= r - 1'b1;
          end
        end
        DONE: lines_last <= n;
        default: ;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  logic [3:0]         bonus;
  logic [SCORE_W:0]   sum;

  always_comb begin
    case (n)
      5'd0:    bonus = 4'd0;
      5'd1:    bonus = 4'd1;
      5'd2:    bonus = 4'd3;
      5'd3:    bonus = 4'd5;
      default: bonus = 4'd8;
    endcase
    sum = {1'b0, score_q} + {{(SCORE_W-3){1'b0}}, bonus};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score_q <= '0;
    end else if (state == DONE) begin
      score_q <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_tetris_line_clear.sv
// Self-checking bench for tetris_line_clear: directed cases plus random fields against a row-compaction model.
module tb_tetris_line_clear;

  localparam int ROWS = 20;
  localparam int COLS = 20;
  localparam int W    = ROWS * COLS;
  localparam int SW_M = 16;
  localparam int SW_S = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start_m = 1'b0;
  logic            start_s = 1'b0;
  logic [W-1:0]    field_in = '0;

  logic [W-1:0]    field_out_m, field_out_s;
  logic            busy_m, busy_s, done_m, done_s;
  logic [4:0]      lines_last_m, lines_last_s;
  logic [SW_M-1:0] score_m;
  logic [SW_S-1:0] score_s;

  int vectors = 0;
  int miscompares = 0;
  int exp_score_m = 0;
  int exp_score_s = 0;

  always #5 clock = ~clock;

  tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW_M)) dut (
    .clock(clock), .reset(reset), .start(start_m), .field_in(field_in),
    .field_out(field_out_m), .busy(busy_m), .done(done_m),
    .lines_last(lines_last_m), .score(score_m)
  );

  // Narrow-score instance so saturation is reachable in a few passes.
  tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW_S)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .field_in(field_in),
    .field_out(field_out_s), .busy(busy_s), .done(done_s),
    .lines_last(lines_last_s), .score(score_s)
  );

  // Reference: drop full rows, stack survivors at the bottom in original order.
  function automatic void ref_clear(input logic [W-1:0] f, output logic [W-1:0] res, output int n);
    logic [COLS-1:0] keep [$];
    logic [COLS-1:0] row;
    n = 0;
    for (int rr = ROWS - 1; rr >= 0; rr--) begin
      row = f[rr*COLS +: COLS];
      if (row == {COLS{1'b1}}) n++;
      else keep.push_back(row);
    end
    res = '0;
    for (int i = 0; i < keep.size(); i++) res[(ROWS-1-i)*COLS +: COLS] = keep[i];
  endfunction

  function automatic int score_after(input int s, input int n, input int w);
`ifdef LINE_CLEAR_SCORE_EN
    int b;
    int mx;
    b  = (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 3 : (n == 3) ? 5 : 8;
    mx = (1 << w) - 1;
    return (s + b > mx) ? mx : s + b;
`else
    return 0 * (s + n + w);
`endif
  endfunction

  // Drives one pass and reports observations; lat counts edges after the accepting edge until done is seen.
  task automatic do_pass(input bit sel, input logic [W-1:0] f, input int repulse,
                         output int lat, output logic [W-1:0] fo, output int ll, output int sc,
                         output int dcnt, output bit busy_ok, output bit busy_end);
    logic cd, cb;
    lat = -1; fo = '0; ll = -1; sc = -1; dcnt = 0; busy_ok = 1'b1; busy_end = 1'b1;
    field_in = f;
    if (sel) start_s = 1'b1; else start_m = 1'b1;
    @(posedge clock); #1;
    start_m = 1'b0; start_s = 1'b0;
    field_in = {13{$urandom}};
    for (int c = 1; c <= 70; c++) begin
      @(posedge clock); #1;
      start_m = 1'b0; start_s = 1'b0;
      cd = sel ? done_s : done_m;
      cb = sel ? busy_s : busy_m;
      if (cd) begin
        dcnt++;
        if (lat < 0) lat = c;
      end
      if (lat < 0 && !cb) busy_ok = 1'b0;
      if (lat == c && !cb) busy_ok = 1'b0;
      if (lat >= 0 && c == lat + 1) begin
        fo = sel ? field_out_s : field_out_m;
        ll = sel ? int'(lines_last_s) : int'(lines_last_m);
        sc = sel ? int'(score_s) : int'(score_m);
      end
      if (c == 70) busy_end = cb;
      if (c == repulse) begin
        field_in = {13{$urandom}};
        if (sel) start_s = 1'b1; else start_m = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    vectors++; if (field_out_m !== '0) begin miscompares++; $display("FAIL reset_field got %h want 0", field_out_m); end
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_m); end
    vectors++; if (done_m !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_m); end
    vectors++; if (lines_last_m !== 5'd0) begin miscompares++; $display("FAIL reset_lines got %0d want 0", lines_last_m); end
    vectors++; if (score_m !== '0) begin miscompares++; $display("FAIL reset_score got %0d want 0", score_m); end
    reset = 1'b0;
    exp_score_m = 0; exp_score_s = 0;
  endtask

  task automatic test_empty();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo;
    do_pass(1'b0, '0, 0, lat, fo, ll, sc, dc, bo, be);
    exp_score_m = score_after(exp_score_m, 0, SW_M);
    vectors++; if (lat !== ROWS) begin miscompares++; $display("FAIL empty_latency got %0d want %0d", lat, ROWS); end
    vectors++; if (fo !== '0) begin miscompares++; $display("FAIL empty_field got %h want 0", fo); end
    vectors++; if (ll !== 0) begin miscompares++; $display("FAIL empty_lines got %0d want 0", ll); end
    vectors++; if (sc !== exp_score_m) begin miscompares++; $display("FAIL empty_score got %0d want %0d", sc, exp_score_m); end
  endtask

  task automatic test_single();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo, f, want;
    f = '0; f[19*COLS +: COLS] = '1; f[18*COLS + 3] = 1'b1;
    want = '0; want[19*COLS + 3] = 1'b1;
    do_pass(1'b0, f, 0, lat, fo, ll, sc, dc, bo, be);
    exp_score_m = score_after(exp_score_m, 1, SW_M);
    vectors++; if (lat !== ROWS + 1) begin miscompares++; $display("FAIL single_latency got %0d want %0d", lat, ROWS + 1); end
    vectors++; if (fo !== want) begin miscompares++; $display("FAIL single_field got %h want %h", fo, want); end
    vectors++; if (ll !== 1) begin miscompares++; $display("FAIL single_lines got %0d want 1", ll); end
    vectors++; if (sc !== exp_score_m) begin miscompares++; $display("FAIL single_score got %0d want %0d", sc, exp_score_m); end
  endtask

  task automatic test_multi();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo, f, want;
    f = '0;
    f[19*COLS +: COLS] = '1; f[17*COLS +: COLS] = '1; f[15*COLS +: COLS] = '1;
    f[16*COLS + 0] = 1'b1; f[18*COLS + 5] = 1'b1; f[14*COLS + 9] = 1'b1;
    want = '0; want[19*COLS + 5] = 1'b1; want[18*COLS + 0] = 1'b1; want[17*COLS + 9] = 1'b1;
    do_pass(1'b0, f, 0, lat, fo, ll, sc, dc, bo, be);
    exp_score_m = score_after(exp_score_m, 3, SW_M);
    vectors++; if (lat !== ROWS + 3) begin miscompares++; $display("FAIL multi_latency got %0d want %0d", lat, ROWS + 3); end
    vectors++; if (fo !== want) begin miscompares++; $display("FAIL multi_field got %h want %h", fo, want); end
    vectors++; if (ll !== 3) begin miscompares++; $display("FAIL multi_lines got %0d want 3", ll); end
    vectors++; if (sc !== exp_score_m) begin miscompares++; $display("FAIL multi_score got %0d want %0d", sc, exp_score_m); end
  endtask

  task automatic test_all_full();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo;
    do_pass(1'b0, '1, 0, lat, fo, ll, sc, dc, bo, be);
    exp_score_m = score_after(exp_score_m, ROWS, SW_M);
    vectors++; if (lat !== 2 * ROWS) begin miscompares++; $display("FAIL full_latency got %0d want %0d", lat, 2 * ROWS); end
    vectors++; if (fo !== '0) begin miscompares++; $display("FAIL full_field got %h want 0", fo); end
    vectors++; if (ll !== ROWS) begin miscompares++; $display("FAIL full_lines got %0d want %0d", ll, ROWS); end
    vectors++; if (sc !== exp_score_m) begin miscompares++; $display("FAIL full_score got %0d want %0d", sc, exp_score_m); end
  endtask

  task automatic test_saturate();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo, f;
    int plan [4] = '{4, 2, 1, 4};
    foreach (plan[i]) begin
      f = '0;
      for (int k = 0; k < plan[i]; k++) f[(ROWS-1-k)*COLS +: COLS] = '1;
      f[2*COLS + i] = 1'b1;
      do_pass(1'b1, f, 0, lat, fo, ll, sc, dc, bo, be);
      exp_score_s = score_after(exp_score_s, plan[i], SW_S);
      vectors++; if (sc !== exp_score_s) begin miscompares++; $display("FAIL sat_score[%0d] got %0d want %0d", i, sc, exp_score_s); end
      vectors++; if (ll !== plan[i]) begin miscompares++; $display("FAIL sat_lines[%0d] got %0d want %0d", i, ll, plan[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo, f, want; int n;
    f = '0; f[19*COLS +: COLS] = '1; f[18*COLS +: COLS] = '1; f[10*COLS + 7] = 1'b1;
    ref_clear(f, want, n);
    do_pass(1'b0, f, 4, lat, fo, ll, sc, dc, bo, be);
    exp_score_m = score_after(exp_score_m, n, SW_M);
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL b2b_done_count got %0d want 1", dc); end
    vectors++; if (bo !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_window got %b want 1", bo); end
    vectors++; if (be !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_after got %b want 0", be); end
    vectors++; if (lat !== ROWS + 2) begin miscompares++; $display("FAIL b2b_latency got %0d want %0d", lat, ROWS + 2); end
    vectors++; if (fo !== want) begin miscompares++; $display("FAIL b2b_field got %h want %h", fo, want); end
    vectors++; if (int'(lines_last_m) !== 2) begin miscompares++; $display("FAIL b2b_lines_hold got %0d want 2", lines_last_m); end
    vectors++; if (int'(score_m) !== exp_score_m) begin miscompares++; $display("FAIL b2b_score got %0d want %0d", score_m, exp_score_m); end
  endtask

  task automatic test_random();
    int lat, ll, sc, dc; bit bo, be; logic [W-1:0] fo, f, want; int n;
    logic [COLS-1:0] row;
    for (int p = 0; p < 25; p++) begin
      for (int rr = 0; rr < ROWS; rr++) begin
        row = COLS'($urandom);
        if ($urandom_range(3) == 0) row = '1;
        f[rr*COLS +: COLS] = row;
      end
      ref_clear(f, want, n);
      do_pass(1'b0, f, 0, lat, fo, ll, sc, dc, bo, be);
      exp_score_m = score_after(exp_score_m, n, SW_M);
      vectors++; if (lat !== ROWS + n) begin miscompares++; $display("FAIL rand[%0d]_latency got %0d want %0d", p, lat, ROWS + n); end
      vectors++; if (fo !== want) begin miscompares++; $display("FAIL rand[%0d]_field got %h want %h", p, fo, want); end
      vectors++; if (ll !== n) begin miscompares++; $display("FAIL rand[%0d]_lines got %0d want %0d", p, ll, n); end
      vectors++; if (sc !== exp_score_m) begin miscompares++; $display("FAIL rand[%0d]_score got %0d want %0d", p, sc, exp_score_m); end
      vectors++; if (dc !== 1) begin miscompares++; $display("FAIL rand[%0d]_done_count got %0d want 1", p, dc); end
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] f;
    int dc;
    f = '0; f[19*COLS +: COLS] = '1; f[18*COLS +: COLS] = '1; f[5*COLS + 2] = 1'b1;
    field_in = f; start_m = 1'b1;
    @(posedge clock); #1;
    start_m = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    exp_score_m = 0; exp_score_s = 0;
    vectors++; if (field_out_m !== '0) begin miscompares++; $display("FAIL abort_field got %h want 0", field_out_m); end
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy_m); end
    vectors++; if (int'(score_m) !== exp_score_m) begin miscompares++; $display("FAIL abort_score got %0d want 0", score_m); end
    reset = 1'b0;
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done_m) dc++;
    end
    vectors++; if (dc !== 0) begin miscompares++; $display("FAIL abort_done_count got %0d want 0", dc); end
    vectors++; if (lines_last_m !== 5'd0) begin miscompares++; $display("FAIL abort_lines got %0d want 0", lines_last_m); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_multi();
    test_all_full();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
